// File: rtl/bitser_pkg.sv
// Shared constants for the bit serializer: default frame width and FSM state codes.
package bitser_pkg;

   localparam int BITSER_WIDTH = 8;

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] SHIFT = 1'b1;

endpackage

// File: rtl/bitser_hold_reg.sv
// One-entry holding register for the bit serializer: stores a word while a frame is
// still shifting and exposes ready as the inverse of its valid flag.
module bitser_hold_reg
   import bitser_pkg::*;
#(
   parameter int WIDTH = BITSER_WIDTH
) (
   input  logic             clk,
   input  logic             areset_n,
   input  logic             wr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd,
   output logic [WIDTH-1:0] data,
   output logic             valid,
   output logic             ready
);

   // wr requires ready (valid == 0) and rd requires valid, so they never coincide
   always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) begin
         valid <= 1'b0;
         data  <= '0;
      end else if (wr) begin
         valid <= 1'b1;
         data  <= wr_data;
      end else if (rd) begin
         valid <= 1'b0;
      end
   end

   assign ready = !valid;

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial LSB-first framer with valid/ready input and first/last strobes.
// Optional BITSER_STALL_EN adds a ser_stall input that freezes the shifter.
module bit_serializer
   import bitser_pkg::*;
#(
   parameter int WIDTH = BITSER_WIDTH
) (
   input  logic             clk,
   input  logic             areset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
`ifdef BITSER_STALL_EN
   input  logic             ser_stall,
`endif
   output logic             ser_bit,
   output logic             ser_valid,
   output logic             ser_first,
   output logic             ser_last,
   output logic             busy
);

   localparam int               CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

   logic [0:0]       state;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] sr;

   logic             stall;
   logic             shifting;
   logic             advance;
   logic             at_last;
   logic             xfer;
   logic             load_direct;
   logic             hold_wr;
   logic             hold_rd;
   logic             hold_valid;
   logic [WIDTH-1:0] hold_data;

`ifdef BITSER_STALL_EN
   assign stall = ser_stall;
`else
   assign stall = 1'b0;
`endif

   bitser_hold_reg #(
      .WIDTH (WIDTH)
   ) u_hold (
      .clk      (clk),
      .areset_n (areset_n),
      .wr       (hold_wr),
      .wr_data  (in_data),
      .rd       (hold_rd),
      .data     (hold_data),
      .valid    (hold_valid),
      .ready    (in_ready)
   );

   // A transfer bypasses the holding register when the shifter is idle or is
   // finishing its last bit with nothing queued; otherwise it is parked.
   always_comb begin
      shifting    = (state == SHIFT);
      advance     = shifting && !stall;
      at_last     = (cnt == LAST);
      xfer        = in_valid && in_ready;
      load_direct = xfer && (!shifting || (advance && at_last && !hold_valid));
      hold_rd     = advance && at_last && hold_valid;
      hold_wr     = xfer && !load_direct;
   end

   always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) begin
         state <= IDLE;
         cnt   <= '0;
         sr    <= '0;
      end else if (hold_rd) begin
         sr    <= hold_data;
         cnt   <= '0;
         state <= SHIFT;
      end else if (load_direct) begin
         sr    <= in_data;
         cnt   <= '0;
         state <= SHIFT;
      end else if (advance) begin
         if (at_last) begin
            state <= IDLE;
         end else begin
            sr  <= sr >> 1;
            cnt <= cnt + 1'b1;
         end
      end
   end

   assign ser_bit   = sr[0];
   assign ser_valid = shifting && !stall;
   assign ser_first = shifting && (cnt == '0);
   assign ser_last  = shifting && at_last;
   assign busy      = shifting || hold_valid;

endmodule

// File: tb/tb_bit_serializer.sv
// Randomized self-checking bench for bit_serializer against a frame/queue reference model.
module tb_bit_serializer;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         areset_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_data;
   logic         ser_stall_i;
   logic         ser_bit;
   logic         ser_valid;
   logic         ser_first;
   logic         ser_last;
   logic         busy;

`ifdef BITSER_STALL_EN
   localparam bit STALL_EN = 1'b1;
`else
   localparam bit STALL_EN = 1'b0;
`endif

   bit_serializer #(
      .WIDTH (W)
   ) dut (
      .clk       (clk),
      .areset_n  (areset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
`ifdef BITSER_STALL_EN
      .ser_stall (ser_stall_i),
`endif
      .ser_bit   (ser_bit),
      .ser_valid (ser_valid),
      .ser_first (ser_first),
      .ser_last  (ser_last),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   // reference model: current word, bit position (-1 = idle), queue of waiting words
   int           pos = -1;
   logic [W-1:0] cur = '0;
   logic [W-1:0] pend[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   task automatic compare_all(input logic st);
      logic active;
      active = (pos >= 0);
      check("in_ready",  in_ready,  pend.size() == 0);
      check("ser_valid", ser_valid, active && !st);
      check("ser_first", ser_first, active && pos == 0);
      check("ser_last",  ser_last,  active && pos == W - 1);
      check("busy",      busy,      active || pend.size() != 0);
      if (active) check("ser_bit", ser_bit, cur[pos]);
   endtask

   task automatic model_step(input logic v, input logic [W-1:0] d, input logic st);
      logic xf;
      xf = v && (pend.size() == 0);
      if (pos >= 0 && !st) begin
         pos++;
         if (pos == W) begin
            if (pend.size() != 0) begin
               cur = pend.pop_front();
               pos = 0;
            end else begin
               pos = -1;
            end
         end
      end
      if (xf) begin
         if (pos < 0) begin
            cur = d;
            pos = 0;
         end else begin
            pend.push_back(d);
         end
      end
   endtask

   // one clock: drive inputs just after negedge, compare, let the edge happen, update model
   task automatic cyc(input logic v, input logic [W-1:0] d, input logic st);
      logic s;
      s = st && STALL_EN;
      in_valid    = v;
      in_data     = d;
      ser_stall_i = s;
      #1;
      compare_all(s);
      @(posedge clk);
      model_step(v, d, s);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, W'($urandom), 1'b0);
   endtask

   initial begin
      logic [W-1:0] words[3];
      int           k;
      int           budget;

      areset_n    = 1'b0;
      in_valid    = 1'b0;
      in_data     = '0;
      ser_stall_i = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_ser_bit",   ser_bit,   1'b0);
      check("rst_ser_valid", ser_valid, 1'b0);
      check("rst_ser_first", ser_first, 1'b0);
      check("rst_ser_last",  ser_last,  1'b0);
      check("rst_busy",      busy,      1'b0);
      check("rst_in_ready",  in_ready,  1'b1);
      areset_n = 1'b1;
      @(negedge clk);

      // single frame 8'h2C
      cyc(1'b1, 8'h2C, 1'b0);
      idle(10);

      // back-to-back 01 then FF
      cyc(1'b1, 8'h01, 1'b0);
      cyc(1'b1, 8'hFF, 1'b0);
      idle(18);

      // in_valid held high across three words
      words[0] = 8'h3C; words[1] = 8'hC3; words[2] = 8'h96;
      k = 0;
      budget = 0;
      while (k < 3 && budget < 100) begin
         logic acc;
         acc = (pend.size() == 0);
         cyc(1'b1, words[k], 1'b0);
         if (acc) k++;
         budget++;
      end
      check("three_words_accepted", k, 3);
      idle(30);

      // transfer coinciding with ser_last, holding register empty
      cyc(1'b1, 8'h5A, 1'b0);
      idle(7);
      cyc(1'b1, 8'hE7, 1'b0);
      #1;
      check("no_bubble_first", ser_first, 1'b1);
      check("no_bubble_valid", ser_valid, 1'b1);
      idle(10);

      // asynchronous reset mid-frame with a word pending
      cyc(1'b1, 8'hA5, 1'b0);
      cyc(1'b1, 8'h77, 1'b0);
      idle(2);
      #2;
      areset_n = 1'b0;
      #1;
      check("arst_ser_valid", ser_valid, 1'b0);
      check("arst_ser_bit",   ser_bit,   1'b0);
      check("arst_busy",      busy,      1'b0);
      check("arst_in_ready",  in_ready,  1'b1);
      check("arst_ser_first", ser_first, 1'b0);
      pos = -1;
      pend.delete();
      @(negedge clk);
      @(negedge clk);
      areset_n = 1'b1;
      idle(12);

      // stall during bit 2 of 8'h2C (only meaningful with the stall port)
      cyc(1'b1, 8'h2C, 1'b0);
      idle(2);
      for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b1);
      idle(10);

      // randomized traffic
      for (int i = 0; i < 4000; i++) begin
         cyc(($urandom_range(0, 99) < 45), W'($urandom), ($urandom_range(0, 99) < 15));
      end
      idle(24);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
